key_event_fifo: RTL and testbench
=================================

// Module: key_event_fifo
// PURPOSE
//  Converts the five debounced key levels into one-shot key events and queues them for the key control FSM.
//  Sits between the key debouncers and the key control stage, so bursts and simultaneous presses are never lost.
//  Presents a show-ahead FIFO with a valid/read handshake, plus full, count and sticky overflow status.
// PARAMETERS
//  DEPTH       8           FIFO entries; must be a power of 2, >= 2
//  AW          3           log2(DEPTH); pointer width
//  REPEAT_DLY  50_000_000  hold cycles before first auto-repeat (0.5 s @100 MHz); KEY_EVT_REPEAT_EN only
//  REPEAT_PER  20_000_000  cycles between subsequent repeats (0.2 s); KEY_EVT_REPEAT_EN only
// PORTS
//  clk100mhz  in   1     system clock, 100 MHz
//  clr        in   1     asynchronous active-low reset
//  key_lvl    in   5     debounced levels, 1 = pressed: [0]wei [1]shuzi [2]enter [3]input [4]disp
//  evt_rd     in   1     pop head entry; ignored when evt_valid=0
//  clr_ovf    in   1     synchronous clear of evt_ovf
//  evt_valid  out  1     FIFO not empty
//  evt_code   out  3     head entry: 1=wei 2=shuzi 3=enter 4=input 5=disp; 0 when empty
//  evt_full   out  1     count == DEPTH
//  evt_cnt    out  AW+1  entries held, 0..DEPTH
//  evt_ovf    out  1     sticky: an event was dropped because the FIFO was full
// BEHAVIOUR
//  - Reset (clr=0, async): FIFO empty, pointers 0, pending mask 0, evt_ovf 0, evt_valid 0, evt_code 0,
//    evt_cnt 0, evt_full 0. Level history lvl_d resets to 5'b11111, so a key held through reset release
//    produces no event until it is released and pressed again.
//  - Edge detect: lvl_q <= key_lvl; lvl_d <= lvl_q; press = lvl_q & ~lvl_d; pending <= (pending & ~served) | press.
//  - Serialiser: at most one write per cycle. served = lowest set bit of pending (bit0 highest priority);
//    code = bit index + 1. Several simultaneous presses are enqueued on consecutive cycles in priority order.
//    A re-press of a key still pending merges into its pending bit.
//  - Latency: key_lvl rise sampled at edge E0 -> pending set at E1 -> written at E2; evt_valid=1 after E2
//    when the FIFO was empty.
//  - Read: show-ahead. evt_code is the head combinationally from storage; evt_rd & evt_valid advances
//    the read pointer at the next edge.
//  - Write when full: accepted if evt_rd is also asserted that cycle (count unchanged). Otherwise the
//    served event is dropped, its pending bit is cleared, and evt_ovf is set.
//  - Simultaneous write and read when not empty: count unchanged, both pointers advance.
//  - Simultaneous write and read when empty: the read is ignored and the write is accepted.
//  - Pointers wrap modulo DEPTH. evt_cnt/evt_full come from a registered count, never from pointer compare.
//  - evt_ovf: set has priority over clr_ovf in the same cycle; clears only via clr_ovf or reset.
//  - Reset mid-operation discards all queued and pending events immediately (async).
// CONFIGURATION
//  KEY_EVT_REPEAT_EN defined: auto-repeat is enabled.
//   - A 27-bit hold counter clears whenever lvl_q != lvl_d or lvl_q is not one-hot.
//   - With exactly one key held, the counter injects a press of that key into pending at count
//     REPEAT_DLY-1, then every REPEAT_PER cycles after that.
//   - Injected events obey the same priority, full and overflow rules as real presses.
//  KEY_EVT_REPEAT_EN undefined: no counter logic; a held key yields exactly one event; REPEAT_* are unused.
// TESTING
//  1. Pulse key_lvl[2] high for 10 cycles, evt_rd=0 -> evt_valid=1, evt_code=3 and evt_cnt=1 after E2;
//     evt_rd for 1 cycle -> evt_cnt=0, evt_code=0.
//  2. key_lvl=5'b10101 in one cycle -> FIFO holds codes 1, 3, 5 in that order; the writes land on three consecutive edges.
//  3. 9 separate presses of key 1, no reads -> evt_full=1 and evt_cnt=8 after the 8th; the 9th is dropped
//     and evt_ovf=1; clr_ovf pulse -> evt_ovf=0 with the FIFO unchanged.
//  4. FIFO full, new press arriving with evt_rd=1 in the write cycle -> evt_cnt stays 8, evt_ovf stays 0,
//     oldest entry popped, new code at the tail.
//  5. 4 entries queued plus pending presses, then clr=0 for 1 cycle with key_lvl held -> all outputs 0;
//     no event until the key is released and re-pressed.
//  6. KEY_EVT_REPEAT_EN with REPEAT_DLY=10, REPEAT_PER=4: hold key_lvl[1] for 30 cycles -> code 2 once on
//     press, then at hold cycles ~10, 14, 18, 22, 26 (6 events total); holding 2 keys gives no repeats.

Source files
------------

// File: rtl/key_event_fifo.sv
// Turns debounced key levels into one-shot key events and queues them in a show-ahead FIFO.
// Define KEY_EVT_REPEAT_EN to add auto-repeat for a single held key.
module key_event_fifo #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AW         = 3,
  parameter int unsigned REPEAT_DLY = 50_000_000,
  parameter int unsigned REPEAT_PER = 20_000_000
) (
  input  logic          clk100mhz,
  input  logic          clr,
  input  logic [4:0]    key_lvl,
  input  logic          evt_rd,
  input  logic          clr_ovf,
  output logic          evt_valid,
  output logic [2:0]    evt_code,
  output logic          evt_full,
  output logic [AW:0]   evt_cnt,
  output logic          evt_ovf
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [4:0]    r_lvl_q, r_lvl_d, r_pend;
  logic [4:0]    w_press, w_served, w_rep;
  logic [2:0]    w_code;
  logic          w_wr_req, w_rd_en, w_wr_acc, w_drop;
  logic [2:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_cnt, w_cnt_nxt;
  logic          r_valid, r_full, r_ovf;

  assign w_press  = (r_lvl_q & ~r_lvl_d) | w_rep;
  assign w_served = r_pend & (~r_pend + 5'd1);
  assign w_wr_req = |r_pend;
  assign w_rd_en  = evt_rd & r_valid;
  assign w_wr_acc = w_wr_req & (~r_full | w_rd_en);
  assign w_drop   = w_wr_req & r_full & ~w_rd_en;

  // Event code of the lowest pending key
  always_comb begin
    w_code = 3'd0;
    case (w_served)
      5'b00001: w_code = 3'd1;
      5'b00010: w_code = 3'd2;
      5'b00100: w_code = 3'd3;
      5'b01000: w_code = 3'd4;
      5'b10000: w_code = 3'd5;
      default:  w_code = 3'd0;
    endcase
  end

  // Next occupancy from accepted write and effective read
  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_wr_acc, w_rd_en})
      2'b10:   w_cnt_nxt = r_cnt + {{AW{1'b0}}, 1'b1};
      2'b01:   w_cnt_nxt = r_cnt - {{AW{1'b0}}, 1'b1};
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Level history starts all-ones so keys held through reset stay silent until re-pressed
  always_ff @(posedge clk100mhz or negedge clr) begin
    if (!clr) begin
      r_lvl_q <= 5'b11111;
      r_lvl_d <= 5'b11111;
      r_pend  <= 5'd0;
    end else begin
      r_lvl_q <= key_lvl;
      r_lvl_d <= r_lvl_q;
      r_pend  <= (r_pend & ~w_served) | w_press;
    end
  end

  // FIFO pointers, registered count and status flags
  always_ff @(posedge clk100mhz or negedge clr) begin
    if (!clr) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_cnt    <= {(AW+1){1'b0}};
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      if (w_rd_en)  r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != {(AW+1){1'b0}});
      r_full  <= (w_cnt_nxt == C_DEPTH);
    end
  end

  // Entry storage; only entries below the count are ever presented
  always_ff @(posedge clk100mhz) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= w_code;
  end

  // Sticky overflow; a drop wins over a same-cycle clear
  always_ff @(posedge clk100mhz or negedge clr) begin
    if (!clr) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef KEY_EVT_REPEAT_EN
  localparam logic [26:0] C_FIRST  = 27'(REPEAT_DLY - 1);
  localparam logic [26:0] C_NEXT   = 27'(REPEAT_DLY - 1 + REPEAT_PER);
  localparam logic [26:0] C_RELOAD = 27'(REPEAT_DLY);

  logic [26:0] r_hold;
  logic        w_one_hot, w_hold_clr, w_inject;

  assign w_one_hot  = (r_lvl_q != 5'd0) && ((r_lvl_q & (r_lvl_q - 5'd1)) == 5'd0);
  assign w_hold_clr = (r_lvl_q != r_lvl_d) || !w_one_hot;
  assign w_inject   = !w_hold_clr && ((r_hold == C_FIRST) || (r_hold == C_NEXT));
  assign w_rep      = w_inject ? r_lvl_q : 5'd0;

  // Hold timer folds back after each periodic repeat instead of growing unbounded
  always_ff @(posedge clk100mhz or negedge clr) begin
    if (!clr) begin
      r_hold <= 27'd0;
    end else if (w_hold_clr) begin
      r_hold <= 27'd0;
    end else if (r_hold == C_NEXT) begin
      r_hold <= C_RELOAD;
    end else begin
      r_hold <= r_hold + 27'd1;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (REPEAT_DLY != REPEAT_PER);
  assign w_rep        = 5'd0;
`endif

  assign evt_valid = r_valid;
  assign evt_code  = r_valid ? r_mem[r_rd_ptr] : 3'd0;
  assign evt_full  = r_full;
  assign evt_cnt   = r_cnt;
  assign evt_ovf   = r_ovf;

endmodule

// File: tb/tb_key_event_fifo.sv
// Bench for key_event_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_key_event_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int RD    = 10;
  localparam int RP    = 4;

  logic          clk100mhz = 1'b0;
  logic          clr       = 1'b0;
  logic [4:0]    key_lvl   = 5'd0;
  logic          evt_rd    = 1'b0;
  logic          clr_ovf   = 1'b0;
  logic          evt_valid;
  logic [2:0]    evt_code;
  logic          evt_full;
  logic [AW:0]   evt_cnt;
  logic          evt_ovf;

  int    n_pass  = 0;
  int    n_fail  = 0;
  int    n_total = 0;
  string cur_tag = "init";

  int         q[$];
  logic [4:0] m_pend, m_l1, m_l2;
  logic       m_ovf;
  int         m_held;

  always #5 clk100mhz = ~clk100mhz;

  key_event_fifo #(.DEPTH(DEPTH), .AW(AW), .REPEAT_DLY(RD), .REPEAT_PER(RP)) dut (
    .clk100mhz (clk100mhz),
    .clr       (clr),
    .key_lvl   (key_lvl),
    .evt_rd    (evt_rd),
    .clr_ovf   (clr_ovf),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_full  (evt_full),
    .evt_cnt   (evt_cnt),
    .evt_ovf   (evt_ovf)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pend = 5'd0;
    m_ovf  = 1'b0;
    m_l1   = 5'h1f;
    m_l2   = 5'h1f;
    m_held = 0;
  endtask

  // One clock edge of behaviour, using the inputs present just before the edge
  task automatic model_edge();
    logic [4:0] press, served;
    int         code;
    bit         rd, drop;
    press = m_l1 & ~m_l2;
`ifdef KEY_EVT_REPEAT_EN
    begin
      bit qual;
      qual = (m_l1 == m_l2) && ($countones(m_l1) == 1);
      if (qual && m_held >= RD - 1 && ((m_held - (RD - 1)) % RP) == 0) press = press | m_l1;
      m_held = qual ? m_held + 1 : 0;
    end
`endif
    served = 5'd0;
    code   = 0;
    for (int i = 0; i < 5; i++) begin
      if (m_pend[i]) begin
        served[i] = 1'b1;
        code      = i + 1;
        break;
      end
    end
    rd   = evt_rd && (q.size() > 0);
    drop = 1'b0;
    if (rd) void'(q.pop_front());
    if (code != 0) begin
      if (q.size() < DEPTH) q.push_back(code);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    m_pend = (m_pend & ~served) | press;
    m_l2   = m_l1;
    m_l1   = key_lvl;
  endtask

  task automatic check_model();
    chk({cur_tag, "/valid"}, {7'd0, evt_valid}, (q.size() > 0) ? 8'd1 : 8'd0);
    chk({cur_tag, "/code"},  {5'd0, evt_code},  (q.size() > 0) ? 8'(q[0]) : 8'd0);
    chk({cur_tag, "/cnt"},   {4'd0, evt_cnt},   8'(q.size()));
    chk({cur_tag, "/full"},  {7'd0, evt_full},  (q.size() == DEPTH) ? 8'd1 : 8'd0);
    chk({cur_tag, "/ovf"},   {7'd0, evt_ovf},   {7'd0, m_ovf});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      model_edge();
      @(posedge clk100mhz);
      #1;
      check_model();
    end
  endtask

  task automatic do_reset();
    clr = 1'b0;
    model_reset();
    #2;
    chk({cur_tag, "/rst_valid"}, {7'd0, evt_valid}, 8'd0);
    chk({cur_tag, "/rst_code"},  {5'd0, evt_code},  8'd0);
    chk({cur_tag, "/rst_cnt"},   {4'd0, evt_cnt},   8'd0);
    chk({cur_tag, "/rst_full"},  {7'd0, evt_full},  8'd0);
    chk({cur_tag, "/rst_ovf"},   {7'd0, evt_ovf},   8'd0);
    @(posedge clk100mhz);
    #1;
    clr = 1'b1;
  endtask

  task automatic press_key(input logic [4:0] k, input int hold, input int gap);
    key_lvl = k;
    step(hold);
    key_lvl = 5'd0;
    step(gap);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk100mhz);
    #1;
    cur_tag = "reset";
    do_reset();
    step(2);

    cur_tag = "t1";
    key_lvl = 5'b00100;
    step(2);
    chk("t1_lat_e1", {7'd0, evt_valid}, 8'd0);
    step(1);
    chk("t1_lat_e2", {7'd0, evt_valid}, 8'd1);
    chk("t1_code",   {5'd0, evt_code},  8'd3);
    chk("t1_cnt",    {4'd0, evt_cnt},   8'd1);
    step(7);
    key_lvl = 5'd0;
    step(2);
    evt_rd = 1'b1;
    step(1);
    evt_rd = 1'b0;
    chk("t1_pop_cnt",  {4'd0, evt_cnt},  8'd0);
    chk("t1_pop_code", {5'd0, evt_code}, 8'd0);

    cur_tag = "t2";
    key_lvl = 5'b10101;
    step(1);
    key_lvl = 5'd0;
    step(1);
    chk("t2_cnt_e1", {4'd0, evt_cnt}, 8'd0);
    step(1);
    chk("t2_cnt_e2", {4'd0, evt_cnt}, 8'd1);
    step(1);
    chk("t2_cnt_e3", {4'd0, evt_cnt}, 8'd2);
    step(1);
    chk("t2_cnt_e4", {4'd0, evt_cnt}, 8'd3);
    evt_rd = 1'b1;
    chk("t2_head0", {5'd0, evt_code}, 8'd1);
    step(1);
    chk("t2_head1", {5'd0, evt_code}, 8'd3);
    step(1);
    chk("t2_head2", {5'd0, evt_code}, 8'd5);
    step(1);
    evt_rd = 1'b0;
    chk("t2_empty", {4'd0, evt_cnt}, 8'd0);

    cur_tag = "t3";
    repeat (9) press_key(5'b00001, 1, 1);
    step(3);
    chk("t3_full", {7'd0, evt_full}, 8'd1);
    chk("t3_cnt",  {4'd0, evt_cnt},  8'd8);
    chk("t3_ovf",  {7'd0, evt_ovf},  8'd1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    chk("t3_ovf_clr", {7'd0, evt_ovf}, 8'd0);
    chk("t3_cnt_kept", {4'd0, evt_cnt}, 8'd8);

    cur_tag = "t4";
    key_lvl = 5'b00100;
    step(2);
    evt_rd = 1'b1;
    step(1);
    evt_rd  = 1'b0;
    key_lvl = 5'd0;
    chk("t4_cnt",  {4'd0, evt_cnt},  8'd8);
    chk("t4_ovf",  {7'd0, evt_ovf},  8'd0);
    chk("t4_full", {7'd0, evt_full}, 8'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t4_drain", {5'd0, evt_code}, (i < 7) ? 8'd1 : 8'd3);
      evt_rd = 1'b1;
      step(1);
    end
    evt_rd = 1'b0;
    chk("t4_empty", {4'd0, evt_cnt}, 8'd0);

    cur_tag = "t5";
    key_lvl = 5'b01111;
    step(1);
    key_lvl = 5'd0;
    step(5);
    chk("t5_cnt4", {4'd0, evt_cnt}, 8'd4);
    key_lvl = 5'b10001;
    step(2);
    do_reset();
    step(4);
    chk("t5_held_cnt",   {4'd0, evt_cnt},   8'd0);
    chk("t5_held_valid", {7'd0, evt_valid}, 8'd0);
    key_lvl = 5'd0;
    step(2);
    key_lvl = 5'b10001;
    step(4);
    chk("t5_repress_cnt", {4'd0, evt_cnt}, 8'd2);
    evt_rd = 1'b1;
    step(2);
    evt_rd  = 1'b0;
    key_lvl = 5'd0;
    step(2);

    cur_tag = "rnd";
    repeat (400) begin
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(0, 7) == 0) key_lvl[b] = ~key_lvl[b];
      end
      evt_rd  = ($urandom_range(0, 3) == 0);
      clr_ovf = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      step(1);
    end
    key_lvl = 5'd0;
    clr_ovf = 1'b0;
    evt_rd  = 1'b1;
    step(12);
    evt_rd  = 1'b0;

`ifdef KEY_EVT_REPEAT_EN
    cur_tag = "t6";
    step(3);
    key_lvl = 5'b00010;
    step(30);
    key_lvl = 5'd0;
    step(3);
    chk("t6_cnt", {4'd0, evt_cnt}, 8'd6);
    for (int i = 0; i < 6; i++) begin
      chk("t6_code", {5'd0, evt_code}, 8'd2);
      evt_rd = 1'b1;
      step(1);
    end
    evt_rd  = 1'b0;
    key_lvl = 5'b00011;
    step(30);
    key_lvl = 5'd0;
    step(3);
    chk("t6_two_keys_cnt", {4'd0, evt_cnt}, 8'd2);
    evt_rd = 1'b1;
    step(3);
    evt_rd = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
